taillight_sequencer: RTL

//  Parametrised successor to the fixed 3+3 Thunderbird taillight FSM. Drives N_LAMPS

---
 rtl/taillight_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/taillight_sequencer.sv
// Parametrised sequential turn-signal / hazard / brake taillight controller.
// One sequence step per prescaler wrap; all outputs are registered.
module taillight_sequencer #(
    parameter int unsigned N_LAMPS  = 3,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic               CLOCK_50,
    input  logic               Reset,
    input  logic               L,
    input  logic               R,
    input  logic               H,
    input  logic               B,
    output logic [N_LAMPS-1:0] LeftLamps,
    output logic [N_LAMPS-1:0] RightLamps,
    output logic [1:0]         Mode,
    output logic               Tick
);

    localparam int unsigned CntW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned StepW = $clog2(N_LAMPS + 1);
    localparam logic [CntW-1:0]  CntMax  = CntW'(TICK_DIV - 1);
    localparam logic [StepW-1:0] StepMax = StepW'(N_LAMPS);

    typedef enum logic [1:0] {
        ModeIdle   = 2'd0,
        ModeLeft   = 2'd1,
        ModeRight  = 2'd2,
        ModeHazard = 2'd3
    } mode_e;

    mode_e              r_mode, w_mode_d, w_req;
    logic [StepW-1:0]   r_step, w_step_d;
    logic               r_phase, w_phase_d;
    logic [CntW-1:0]    r_cnt, w_cnt_d;
    logic               r_tick, w_tick_d;
    logic [N_LAMPS-1:0] r_left, r_right, w_left_d, w_right_d;
    logic [N_LAMPS-1:0] w_seq, w_brake;
    logic               w_wrap;

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_mode  <= ModeIdle;
            r_step  <= '0;
            r_phase <= 1'b0;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            r_mode  <= w_mode_d;
            r_step  <= w_step_d;
            r_phase <= w_phase_d;
            r_cnt   <= w_cnt_d;
            r_tick  <= w_tick_d;
            r_left  <= w_left_d;
            r_right <= w_right_d;
        end
    end

    always_comb begin
        if (H || (L && R)) begin
            w_req = ModeHazard;
        end else if (L) begin
            w_req = ModeLeft;
        end else if (R) begin
            w_req = ModeRight;
        end else begin
            w_req = ModeIdle;
        end

        w_wrap    = (r_cnt == CntMax);
        w_mode_d  = r_mode;
        w_step_d  = r_step;
        w_phase_d = r_phase;
        w_cnt_d   = w_wrap ? '0 : r_cnt + 1'b1;
        w_tick_d  = w_wrap;

        // A new request restarts the pattern from dark with a fresh prescaler period.
        if (w_req != r_mode) begin
            w_mode_d  = w_req;
            w_step_d  = '0;
            w_phase_d = 1'b0;
            w_cnt_d   = '0;
            w_tick_d  = 1'b0;
        end else if (w_wrap) begin
            unique case (r_mode)
                ModeLeft, ModeRight: w_step_d = (r_step == StepMax) ? '0 : r_step + 1'b1;
                ModeHazard:          w_phase_d = ~r_phase;
                default:             ;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < N_LAMPS; k++) begin
            w_seq[k] = (k < int'(w_step_d));
        end
        w_brake = B ? '1 : '0;

        w_left_d  = w_brake;
        w_right_d = w_brake;
        unique case (w_mode_d)
            ModeLeft:   w_left_d = w_seq;
            ModeRight:  w_right_d = w_seq;
            ModeHazard: begin
                w_left_d  = w_phase_d ? '1 : '0;
                w_right_d = w_phase_d ? '1 : '0;
            end
            default:    ;
        endcase
    end

    assign LeftLamps  = r_left;
    assign RightLamps = r_right;
    assign Mode       = r_mode;
    assign Tick       = r_tick;

endmodule
